score_sequencer: RTL and testbench



---
 rtl/score_pkg.sv | 30 +++
 rtl/score_sequencer_tick_prescaler.sv | 31 +++
 rtl/score_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_score_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types, default constants and {note, band, dur} field helpers for the score sequencer.
package score_pkg;

  localparam int CLK_HZ        = 50000000;
  localparam int UNITS_PER_BAR = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  // The word is packed {note, band, dur} with dur in the least significant bits.
  function automatic logic [31:0] field_dur(input logic [63:0] w, input int dur_w);
    return 32'(w & ((64'd1 << dur_w) - 64'd1));
  endfunction

  function automatic logic [31:0] field_band(input logic [63:0] w, input int band_w,
                                             input int dur_w);
    return 32'((w >> dur_w) & ((64'd1 << band_w) - 64'd1));
  endfunction

  function automatic logic [31:0] field_note(input logic [63:0] w, input int note_w,
                                             input int band_w, input int dur_w);
    return 32'((w >> (band_w + dur_w)) & ((64'd1 << note_w) - 64'd1));
  endfunction

endpackage

// File: rtl/score_sequencer_tick_prescaler.sv
// tick_prescaler: modulo-TICK_DIV counter that freezes when disabled and pulses o_tick on its last count.
module tick_prescaler #(
  parameter int  TICK_DIV = 4,
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  assign o_count = r_count;
  assign o_tick  = i_en && (r_count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/score_sequencer.sv
// score_sequencer: walks a score ROM and plays {note, band, dur} words as timed one-hot notes.
// Define SCORE_SEQUENCER_LOOP_EN to restart at address 0 on the end marker instead of halting.
//
// state | meaning
// IDLE  | waiting for the first pause edge
// FETCH | ROM latency cycle, then decode of the word at addr
// PLAY  | note (or rest) sounding until GAP cycles remain
// GAP   | articulation silence, addr advances on its last cycle
// DONE  | end marker reached, halted until reset
module score_sequencer
  import score_pkg::*;
#(
  parameter int  NOTE_W   = 4,
  parameter int  BAND_W   = 3,
  parameter int  DUR_W    = 5,
  parameter int  ADDR_W   = 16,
  parameter int  TICK_DIV = CLK_HZ / UNITS_PER_BAR,
  parameter int  GAP      = 0,
  localparam int NOTES    = 2**NOTE_W,
  localparam int WORD_W   = NOTE_W + BAND_W + DUR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pause,
  input  logic [WORD_W-1:0] data,
  output logic [ADDR_W-1:0] addr,
  output logic [NOTES-1:0]  signal,
  output logic [BAND_W-1:0] band,
  output logic              en,
  output logic              done
);

  localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] GAP_START = CNT_W'(TICK_DIV - GAP - 1);

  state_t            r_state, w_state_nxt;
  logic              r_pause_q;
  logic              r_en, w_en_nxt;
  logic              r_done, w_done_nxt;
  logic              r_rom_wait, w_rom_wait_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [NOTES-1:0]  r_signal, w_signal_nxt;
  logic [BAND_W-1:0] r_band, w_band_nxt;
  logic [DUR_W-1:0]  r_dur, w_dur_nxt;
  logic [DUR_W-1:0]  r_unit, w_unit_nxt;

  logic [NOTE_W-1:0] w_note;
  logic [BAND_W-1:0] w_band_f;
  logic [DUR_W-1:0]  w_dur_f;
  logic [CNT_W-1:0]  w_count;
  logic              w_edge, w_run, w_presc_en, w_decode, w_tick, w_last_unit, w_note_end;

  assign w_note   = NOTE_W'(field_note(64'(data), NOTE_W, BAND_W, DUR_W));
  assign w_band_f = BAND_W'(field_band(64'(data), BAND_W, DUR_W));
  assign w_dur_f  = DUR_W'(field_dur(64'(data), DUR_W));

  // A pause edge steals its cycle: nothing advances while the run/pause toggle is applied.
  assign w_edge      = pause & ~r_pause_q;
  assign w_run       = r_en & ~w_edge;
  assign w_presc_en  = w_run & ((r_state == ST_PLAY) | (r_state == ST_GAP));
  assign w_last_unit = (r_unit == r_dur - 1'b1);
  assign w_note_end  = w_last_unit & w_tick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_presc_en),
    .i_clr   (w_decode),
    .o_count (w_count),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_en_nxt       = r_en;
    w_done_nxt     = r_done;
    w_rom_wait_nxt = r_rom_wait;
    w_addr_nxt     = r_addr;
    w_signal_nxt   = r_signal;
    w_band_nxt     = r_band;
    w_dur_nxt      = r_dur;
    w_unit_nxt     = r_unit;
    w_decode       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_edge) begin
          w_en_nxt       = 1'b1;
          w_rom_wait_nxt = 1'b1;
          w_state_nxt    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_edge) begin
          w_en_nxt = ~r_en;
        end else if (r_en) begin
          if (r_rom_wait) begin
            w_rom_wait_nxt = 1'b0;
          end else if (w_dur_f == '0) begin
`ifdef SCORE_SEQUENCER_LOOP_EN
            w_addr_nxt     = '0;
            w_rom_wait_nxt = 1'b1;
`else
            w_en_nxt    = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_DONE;
`endif
          end else begin
            w_decode     = 1'b1;
            w_signal_nxt = (w_note == '0) ? '0 : (NOTES'(1) << w_note);
            w_band_nxt   = w_band_f;
            w_dur_nxt    = w_dur_f;
            w_unit_nxt   = '0;
            w_state_nxt  = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        if (w_edge) begin
          w_en_nxt = ~r_en;
        end else if (r_en) begin
          if (w_tick) w_unit_nxt = r_unit + 1'b1;
          if (GAP == 0 && w_note_end) begin
            w_signal_nxt   = '0;
            w_addr_nxt     = r_addr + 1'b1;
            w_unit_nxt     = '0;
            w_rom_wait_nxt = 1'b1;
            w_state_nxt    = ST_FETCH;
          end else if (GAP != 0 && w_last_unit && w_count == GAP_START) begin
            w_signal_nxt = '0;
            w_state_nxt  = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (w_edge) begin
          w_en_nxt = ~r_en;
        end else if (r_en && w_note_end) begin
          w_addr_nxt     = r_addr + 1'b1;
          w_unit_nxt     = '0;
          w_rom_wait_nxt = 1'b1;
          w_state_nxt    = ST_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pause_q  <= 1'b0;
      r_en       <= 1'b0;
      r_done     <= 1'b0;
      r_rom_wait <= 1'b0;
      r_addr     <= '0;
      r_signal   <= '0;
      r_band     <= '0;
      r_dur      <= '0;
      r_unit     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pause_q  <= pause;
      r_en       <= w_en_nxt;
      r_done     <= w_done_nxt;
      r_rom_wait <= w_rom_wait_nxt;
      r_addr     <= w_addr_nxt;
      r_signal   <= w_signal_nxt;
      r_band     <= w_band_nxt;
      r_dur      <= w_dur_nxt;
      r_unit     <= w_unit_nxt;
    end
  end

  // The saved note survives a pause; only the visible line is muted.
  assign signal = r_en ? r_signal : '0;
  assign addr   = r_addr;
  assign band   = r_band;
  assign en     = r_en;
  assign done   = r_done;

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: directed and random scores checked against a remaining-cycles model.
module tb_score_sequencer;

  localparam int NOTE_W   = 4;
  localparam int BAND_W   = 3;
  localparam int DUR_W    = 5;
  localparam int ADDR_W   = 2;
  localparam int TICK_DIV = 4;
  localparam int GAP      = 1;
  localparam int NOTES    = 2**NOTE_W;
  localparam int WORD_W   = NOTE_W + BAND_W + DUR_W;
  localparam int DEPTH    = 2**ADDR_W;
`ifdef SCORE_SEQUENCER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              pause = 1'b0;
  logic [WORD_W-1:0] data  = '0;
  logic [ADDR_W-1:0] addr;
  logic [NOTES-1:0]  signal;
  logic [BAND_W-1:0] band;
  logic              en;
  logic              done;

  logic [WORD_W-1:0] rom [DEPTH];

  score_sequencer #(
    .NOTE_W(NOTE_W), .BAND_W(BAND_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W),
    .TICK_DIV(TICK_DIV), .GAP(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .data(data),
    .addr(addr), .signal(signal), .band(band), .en(en), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) data <= rom[addr];

  // Reference model: a note is just "remaining cycles"; it sounds while more than GAP remain.
  typedef enum {M_IDLE, M_WAIT, M_DECODE, M_NOTE, M_DONE} mph_t;
  mph_t             m_ph;
  logic             m_en, m_done, m_pprev;
  int               m_addr, m_band, m_left;
  logic [NOTES-1:0] m_onehot;

  int checks = 0;
  int errors = 0;
  int hi_cnt = 0;

  function automatic logic [WORD_W-1:0] mk(input int n, input int b, input int d);
    return {NOTE_W'(n), BAND_W'(b), DUR_W'(d)};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph     = M_IDLE;
    m_en     = 1'b0;
    m_done   = 1'b0;
    m_pprev  = 1'b0;
    m_addr   = 0;
    m_band   = 0;
    m_left   = 0;
    m_onehot = '0;
  endtask

  task automatic model_step();
    logic              e;
    logic [WORD_W-1:0] w;
    logic [NOTE_W-1:0] n;
    int                d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e       = pause && !m_pprev;
    m_pprev = pause;
    if (m_ph == M_IDLE) begin
      if (e) begin
        m_en = 1'b1;
        m_ph = M_WAIT;
      end
    end else if (m_ph != M_DONE) begin
      if (e) begin
        m_en = !m_en;
      end else if (m_en) begin
        case (m_ph)
          M_WAIT: m_ph = M_DECODE;
          M_DECODE: begin
            w = rom[m_addr];
            d = int'(w[DUR_W-1:0]);
            n = w[WORD_W-1 -: NOTE_W];
            if (d == 0) begin
              if (LOOP) begin
                m_addr = 0;
                m_ph   = M_WAIT;
              end else begin
                m_ph   = M_DONE;
                m_en   = 1'b0;
                m_done = 1'b1;
              end
            end else begin
              m_band   = int'(w[DUR_W +: BAND_W]);
              m_onehot = (n == '0) ? '0 : (NOTES'(1) << n);
              m_left   = d * TICK_DIV;
              m_ph     = M_NOTE;
            end
          end
          M_NOTE: begin
            m_left--;
            if (m_left == 0) begin
              m_addr = (m_addr + 1) % DEPTH;
              m_ph   = M_WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_out();
    logic [NOTES-1:0] exp_sig;
    exp_sig = (m_ph == M_NOTE && m_en && m_left > GAP) ? m_onehot : '0;
    check_val("signal", 32'(signal), 32'(exp_sig));
    check_val("addr",   32'(addr),   32'(m_addr));
    check_val("band",   32'(band),   32'(m_band));
    check_val("en",     32'(en),     32'(m_en));
    check_val("done",   32'(done),   32'(m_done));
    if (signal != '0) hi_cnt++;
  endtask

  task automatic tick(input logic p);
    @(posedge clk);
    model_step();
    #1 pause = p;
    @(negedge clk);
    check_out();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pause = 1'b0;
    model_reset();
    repeat (2) tick(1'b0);
    rst_n  = 1'b1;
    hi_cnt = 0;
  endtask

  initial begin
    logic p;
    logic wrapped;
    logic [ADDR_W-1:0] prev_addr;
    int d;

    // reset values
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(0, 0, 0);
    do_reset();
    check_val("rst_addr", 32'(addr), 0);
    check_val("rst_signal", 32'(signal), 0);
    check_val("rst_band", 32'(band), 0);
    check_val("rst_en", 32'(en), 0);
    check_val("rst_done", 32'(done), 0);
    repeat (3) tick(1'b0);
    check_val("idle_en", 32'(en), 0);

    // basic note {3,2,2} then end marker
    rom[0] = mk(3, 2, 2);
    rom[1] = mk(0, 0, 0);
    do_reset();
    tick(1'b1);
    repeat (12) tick(1'b0);
    check_val("basic_hi_cycles", hi_cnt, 7);
    check_val("basic_band", 32'(band), 2);
    check_val("basic_addr", 32'(addr), 1);
    repeat (4) tick(1'b0);
    check_val("basic_done", 32'(done), LOOP ? 0 : 1);
    check_val("basic_end_addr", 32'(addr), LOOP ? 0 : 1);
    check_val("basic_end_en", 32'(en), LOOP ? 1 : 0);

    // rest {0,5,1}
    rom[0] = mk(0, 5, 1);
    rom[1] = mk(0, 0, 0);
    do_reset();
    tick(1'b1);
    repeat (8) tick(1'b0);
    check_val("rest_hi_cycles", hi_cnt, 0);
    check_val("rest_band", 32'(band), 5);
    check_val("rest_addr", 32'(addr), 1);

    // mid-note pause on a dur-2 note; the edge cycle still shows the note
    // but consumes no duration, so 7 sounding cycles appear as 8 samples
    rom[0] = mk(5, 1, 2);
    rom[1] = mk(0, 0, 0);
    do_reset();
    tick(1'b1);
    repeat (4) tick(1'b0);
    tick(1'b1);
    repeat (10) tick(1'b1);
    check_val("pause_en", 32'(en), 0);
    check_val("pause_signal", 32'(signal), 0);
    check_val("pause_band", 32'(band), 1);
    tick(1'b0);
    tick(1'b1);
    repeat (8) tick(1'b0);
    check_val("pause_hi_cycles", hi_cnt, 8);
    check_val("pause_addr", 32'(addr), 1);

    // end marker at ROM[2]: loops back to 0 or halts
    rom[0] = mk(1, 1, 1);
    rom[1] = mk(2, 2, 1);
    rom[2] = mk(0, 0, 0);
    rom[3] = mk(9, 4, 1);
    do_reset();
    tick(1'b1);
    repeat (20) tick(1'b0);
    check_val("loop_done", 32'(done), LOOP ? 0 : 1);
    check_val("loop_addr", 32'(addr), LOOP ? 0 : 2);

    // address wrap with four dur-1 notes and no marker
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(i + 1, i, 1);
    do_reset();
    wrapped = 1'b0;
    tick(1'b1);
    for (int i = 0; i < 30; i++) begin
      prev_addr = addr;
      tick(1'b0);
      if (prev_addr == 2'd3 && addr == 2'd0) wrapped = 1'b1;
    end
    check_val("wrap_seen", 32'(wrapped), 1);

    // asynchronous reset in the middle of the second note
    rom[0] = mk(2, 1, 1);
    rom[1] = mk(7, 3, 3);
    rom[2] = mk(0, 0, 0);
    rom[3] = mk(0, 0, 0);
    do_reset();
    tick(1'b1);
    repeat (11) tick(1'b0);
    check_val("pre_rst_signal", 32'(signal), 32'h0080);
    check_val("pre_rst_addr", 32'(addr), 1);
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_signal", 32'(signal), 0);
    check_val("async_rst_addr", 32'(addr), 0);
    check_val("async_rst_en", 32'(en), 0);
    check_val("async_rst_band", 32'(band), 0);
    model_reset();
    repeat (2) tick(1'b0);
    rst_n = 1'b1;
    repeat (5) tick(1'b0);
    check_val("post_rst_idle_en", 32'(en), 0);
    tick(1'b1);
    repeat (4) tick(1'b0);
    check_val("post_rst_signal", 32'(signal), 32'h0004);

    // random scores with random pause toggling
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        d = $urandom_range(1, 3);
        if ($urandom_range(0, 3) == 0) d = 0;
        rom[i] = mk($urandom_range(0, 15), $urandom_range(0, 7), d);
      end
      do_reset();
      p = 1'b1;
      tick(p);
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 5) == 0) p = ~p;
        tick(p);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
